// File: rtl/mux4_rr_arbiter_if.sv
// Bundle between the four requesting control units and the shared operand mux/arbiter.
// The master side drives requests and operands; the slave side returns grant, select and the muxed operand.
interface mux4_rr_arbiter_if #(
    parameter int WIDTH = 5
);
    logic [3:0]         req;
    logic [4*WIDTH-1:0] din;
    logic [3:0]         gnt;
    logic [1:0]         sel;
    logic [WIDTH-1:0]   dout;
    logic               valid;
    logic               expired;

    modport master (
        output req, din,
        input  gnt, sel, dout, valid, expired
    );

    modport slave (
        input  req, din,
        output gnt, sel, dout, valid, expired
    );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning one 4:1 operand mux: grants one requester at a time,
// holds the select in a register and optionally revokes grants after HOLD_MAX cycles.
module mux4_rr_arbiter #(
    parameter int WIDTH    = 5,
    parameter int HOLD_MAX = 4,
    parameter int CNT_W    = 3
) (
    input logic               clk,
    input logic               rst,
    mux4_rr_arbiter_if.slave  bus
);
    typedef enum logic {IDLE, OWN} state_t;

    localparam int                HOLD_LAST_I = (HOLD_MAX == 0) ? 0 : HOLD_MAX - 1;
    localparam logic [CNT_W-1:0]  HOLD_LAST   = CNT_W'(HOLD_LAST_I);
    localparam logic [CNT_W-1:0]  CNT_MAX     = '1;
    localparam bit                HOLD_EN     = (HOLD_MAX != 0);

    state_t           state_q, state_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             expired_q, expired_d;

    logic [1:0]       winner;
    logic [WIDTH-1:0] slice [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_slice
            assign slice[gi] = bus.din[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        winner = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            if (bus.req[ptr_q + 2'(k)]) begin
                winner = ptr_q + 2'(k);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        expired_d = 1'b0;
        case (state_q)
            IDLE: begin
                gnt_d = 4'b0000;
                if (|bus.req) begin
                    gnt_d   = 4'b0001 << winner;
                    sel_d   = winner;
                    cnt_d   = '0;
                    state_d = OWN;
                end
            end
            OWN: begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                if (!bus.req[sel_q] || (HOLD_EN && cnt_q == HOLD_LAST)) begin
                    gnt_d     = 4'b0000;
                    ptr_d     = sel_q + 2'd1;
                    state_d   = IDLE;
                    expired_d = bus.req[sel_q];
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= 4'b0000;
            sel_q     <= 2'd0;
            ptr_q     <= 2'd0;
            cnt_q     <= '0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            expired_q <= expired_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.sel     = sel_q;
    assign bus.valid   = |gnt_q;
    assign bus.expired = expired_q;
    assign bus.dout    = slice[sel_q];
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: one instance with HOLD_MAX=4, one with unlimited hold.
module tb_mux4_rr_arbiter;
    logic clk;
    logic rst;

    mux4_rr_arbiter_if #(.WIDTH(5)) ifa ();
    mux4_rr_arbiter_if #(.WIDTH(5)) ifb ();

    mux4_rr_arbiter #(.WIDTH(5), .HOLD_MAX(4), .CNT_W(3)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    mux4_rr_arbiter #(.WIDTH(5), .HOLD_MAX(0), .CNT_W(3)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] obs;
    logic [7:0] exp_v;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ifa.req = 4'b0000;
        ifb.req = 4'b0000;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        obs   = {ifa.gnt, ifa.sel, ifa.valid, ifa.expired};
        exp_v = 8'b0000_00_0_0;
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL reset_a: got %b want %b", obs, exp_v);
        end else $display("ok reset_a %b", obs);
        obs = {ifb.gnt, ifb.sel, ifb.valid, ifb.expired};
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL reset_b: got %b want %b", obs, exp_v);
        end else $display("ok reset_b %b", obs);
        tick();
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        ifa.din = {5'h1A, 5'h15, 5'h0C, 5'h07};
        ifa.req = 4'b0100;
        tick();
        obs   = {ifa.gnt, ifa.sel, ifa.valid, ifa.expired};
        exp_v = {4'b0100, 2'd2, 1'b1, 1'b0};
        n_cmp++;
        if (obs !== exp_v || ifa.dout !== 5'h15) begin
            n_err++;
            $display("FAIL single_grant: got %b dout %h want %b dout 15", obs, ifa.dout, exp_v);
        end else $display("ok single_grant %b dout %h", obs, ifa.dout);
        ifa.req = 4'b0000;
        tick();
        obs   = {ifa.gnt, ifa.sel, ifa.valid, ifa.expired};
        exp_v = {4'b0000, 2'd2, 1'b0, 1'b0};
        n_cmp++;
        if (obs !== exp_v || ifa.dout !== 5'h15) begin
            n_err++;
            $display("FAIL single_release: got %b dout %h want %b dout 15", obs, ifa.dout, exp_v);
        end else $display("ok single_release %b", obs);
        // ptr should now be 3, so requester 3 wins an all-request round
        ifa.req = 4'b1111;
        tick();
        n_cmp++;
        if (ifa.gnt !== 4'b1000) begin
            n_err++;
            $display("FAIL single_ptr: got gnt %b want 1000", ifa.gnt);
        end else $display("ok single_ptr gnt %b", ifa.gnt);
        ifa.req = 4'b0000;
        tick();
    endtask

    task automatic test_round_robin();
        int owner;
        do_reset();
        ifa.req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            owner = g % 4;
            for (int c = 0; c < 4; c++) begin
                tick();
                obs   = {ifa.gnt, ifa.sel, ifa.valid, ifa.expired};
                exp_v = {4'(4'b0001 << owner), 2'(owner), 1'b1, 1'b0};
                n_cmp++;
                if (obs !== exp_v) begin
                    n_err++;
                    $display("FAIL rr_g%0d_c%0d: got %b want %b", g, c, obs, exp_v);
                end else $display("ok rr_g%0d_c%0d %b", g, c, obs);
            end
            tick();
            obs   = {ifa.gnt, ifa.sel, ifa.valid, ifa.expired};
            exp_v = {4'b0000, 2'(owner), 1'b0, 1'b1};
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL rr_gap%0d: got %b want %b", g, obs, exp_v);
            end else $display("ok rr_gap%0d %b", g, obs);
        end
        ifa.req = 4'b0000;
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        ifa.din = {5'h1A, 5'h15, 5'h0C, 5'h07};
        ifa.req = 4'b0100;
        tick();
        ifa.req = 4'b0000;
        tick();
        ifa.req = 4'b1001;
        tick();
        n_cmp++;
        if (ifa.gnt !== 4'b1000 || ifa.sel !== 2'd3) begin
            n_err++;
            $display("FAIL wrap_first: got gnt %b sel %0d want 1000 sel 3", ifa.gnt, ifa.sel);
        end else $display("ok wrap_first gnt %b", ifa.gnt);
        ifa.req = 4'b0001;
        tick();
        obs   = {ifa.gnt, ifa.sel, ifa.valid, ifa.expired};
        exp_v = {4'b0000, 2'd3, 1'b0, 1'b0};
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL wrap_release: got %b want %b", obs, exp_v);
        end else $display("ok wrap_release %b", obs);
        tick();
        n_cmp++;
        if (ifa.gnt !== 4'b0001 || ifa.sel !== 2'd0 || ifa.dout !== 5'h07) begin
            n_err++;
            $display("FAIL wrap_second: got gnt %b sel %0d dout %h want 0001 sel 0 dout 07",
                     ifa.gnt, ifa.sel, ifa.dout);
        end else $display("ok wrap_second gnt %b", ifa.gnt);
        ifa.req = 4'b0000;
        tick();
    endtask

    task automatic test_no_limit();
        do_reset();
        ifb.din = {5'h1A, 5'h15, 5'h0C, 5'h07};
        ifb.req = 4'b0010;
        for (int c = 0; c < 20; c++) begin
            if (c == 3) ifb.req = 4'b0011;
            tick();
            obs   = {ifb.gnt, ifb.sel, ifb.valid, ifb.expired};
            exp_v = {4'b0010, 2'd1, 1'b1, 1'b0};
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL nolimit_c%0d: got %b want %b", c, obs, exp_v);
            end else $display("ok nolimit_c%0d %b", c, obs);
        end
        ifb.req = 4'b0001;
        tick();
        obs   = {ifb.gnt, ifb.sel, ifb.valid, ifb.expired};
        exp_v = {4'b0000, 2'd1, 1'b0, 1'b0};
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL nolimit_release: got %b want %b", obs, exp_v);
        end else $display("ok nolimit_release %b", obs);
        tick();
        n_cmp++;
        if (ifb.gnt !== 4'b0001 || ifb.dout !== 5'h07) begin
            n_err++;
            $display("FAIL nolimit_next: got gnt %b dout %h want 0001 dout 07", ifb.gnt, ifb.dout);
        end else $display("ok nolimit_next gnt %b", ifb.gnt);
        ifb.req = 4'b0000;
        tick();
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        ifa.req = 4'b0100;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        obs   = {ifa.gnt, ifa.sel, ifa.valid, ifa.expired};
        exp_v = 8'b0000_00_0_0;
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL midreset_async: got %b want %b", obs, exp_v);
        end else $display("ok midreset_async %b", obs);
        #1;
        rst = 1'b0;
        ifa.req = 4'b0110;
        tick();
        n_cmp++;
        if (ifa.gnt !== 4'b0010 || ifa.sel !== 2'd1) begin
            n_err++;
            $display("FAIL midreset_regrant: got gnt %b sel %0d want 0010 sel 1", ifa.gnt, ifa.sel);
        end else $display("ok midreset_regrant gnt %b", ifa.gnt);
        ifa.req = 4'b0000;
        tick();
    endtask

    task automatic test_din_follow();
        do_reset();
        ifa.din = {5'h1A, 5'h15, 5'h0C, 5'h03};
        ifa.req = 4'b0001;
        tick();
        n_cmp++;
        if (ifa.dout !== 5'h03 || ifa.gnt !== 4'b0001) begin
            n_err++;
            $display("FAIL din_before: got dout %h gnt %b want 03 0001", ifa.dout, ifa.gnt);
        end else $display("ok din_before dout %h", ifa.dout);
        ifa.din = {5'h1A, 5'h15, 5'h0C, 5'h1F};
        #1;
        n_cmp++;
        if (ifa.dout !== 5'h1F || ifa.sel !== 2'd0) begin
            n_err++;
            $display("FAIL din_follow: got dout %h sel %0d want 1f sel 0", ifa.dout, ifa.sel);
        end else $display("ok din_follow dout %h", ifa.dout);
        ifa.req = 4'b0000;
        tick();
    endtask

    initial begin
        rst     = 1'b1;
        ifa.req = 4'b0000;
        ifb.req = 4'b0000;
        ifa.din = '0;
        ifb.din = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_no_limit();
        test_reset_mid_grant();
        test_din_follow();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
